// File: rtl/wave_pkg.sv
// Shared types and dimensions for the waveform capture and display stages.
package wave_pkg;

   localparam int unsigned SAMPLE_W      = 12;
   localparam int unsigned OUT_W         = 10;
   localparam int unsigned NUM_POINTS    = 1280;
   localparam int unsigned SCREEN_H      = 1024;
   localparam int unsigned HYST          = 8;
   localparam int unsigned AUTO_TIMEOUT  = 4095;
   localparam int unsigned HOLDOFF_TICKS = 64;
   localparam int unsigned DECIM_W       = 4;
   localparam int unsigned ADDR_W        = 11;
   localparam int unsigned TMO_W         = 12;
   localparam int unsigned HOLD_W        = 7;

   typedef enum logic [1:0] {
      WAIT_TRIG = 2'd0,
      CAPTURE   = 2'd1,
      HOLDOFF   = 2'd2
   } trig_state_t;

   // Rising-slope arm threshold: level minus hysteresis, floored at 0.
   function automatic logic [OUT_W-1:0] arm_below(input logic [OUT_W-1:0] lvl);
      return (lvl > OUT_W'(HYST)) ? lvl - OUT_W'(HYST) : '0;
   endfunction

   // Falling-slope arm threshold: level plus hysteresis, capped at full scale.
   function automatic logic [OUT_W-1:0] arm_above(input logic [OUT_W-1:0] lvl);
      return (lvl < OUT_W'(SCREEN_H - 1 - HYST)) ? lvl + OUT_W'(HYST)
                                                 : OUT_W'(SCREEN_H - 1);
   endfunction

endpackage

// File: rtl/sample_decimator.sv
// Keeps one of every decim+1 valid mic samples and truncates it to display width.
module sample_decimator
   import wave_pkg::*;
(
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [SAMPLE_W-1:0] i_mic,
   input  logic                i_valid,
   input  logic [DECIM_W-1:0]  i_decim,
   output logic                o_tick_c,
   output logic [OUT_W-1:0]    o_s_c
);

   logic [DECIM_W-1:0] r_dcnt;
   logic               w_unused_lsb;

   // Tick on the kept sample; >= also covers decim shrinking below the running count.
   always_comb begin
      o_tick_c     = i_valid && (r_dcnt >= i_decim);
      o_s_c        = i_mic[SAMPLE_W-1 -: OUT_W];
      w_unused_lsb = ^i_mic[SAMPLE_W-OUT_W-1:0];
   end

   // Count valid samples since the last kept one.
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         r_dcnt <= '0;
      end else if (o_tick_c) begin
         r_dcnt <= '0;
      end else if (i_valid) begin
         r_dcnt <= r_dcnt + DECIM_W'(1);
      end
   end

endmodule

// File: rtl/wave_trigger_capture.sv
// Trigger detection with hysteresis and frame capture feeding the waveform display memory.
module wave_trigger_capture
   import wave_pkg::*;
(
   input  logic                clk_sample,
   input  logic                rst_n,
   input  logic [SAMPLE_W-1:0] mic_in,
   input  logic                mic_valid,
   input  logic [DECIM_W-1:0]  decim,
   input  logic [OUT_W-1:0]    trig_level,
   input  logic                trig_slope,
   input  logic                auto_mode,
   input  logic                freeze,
   output logic [OUT_W-1:0]    wave_sample,
   output logic [ADDR_W-1:0]   wr_addr,
   output logic                wr_en,
   output logic                frame_done,
   output logic [1:0]          trig_state
);

   logic               w_tick;
   logic [OUT_W-1:0]   w_s;
   logic               w_arm;
   logic               w_trig;
   logic               w_auto;

   trig_state_t        r_state;
   logic               r_armed;
   logic [TMO_W-1:0]   r_timeout;
   logic [HOLD_W-1:0]  r_hold;
   logic [ADDR_W-1:0]  r_addr;
   logic [OUT_W-1:0]   r_wave;
   logic [ADDR_W-1:0]  r_wr_addr;
   logic               r_wr_en;
   logic               r_frame_done;

   sample_decimator u_decim (
      .i_clk    (clk_sample),
      .i_rst_n  (rst_n),
      .i_mic    (mic_in),
      .i_valid  (mic_valid),
      .i_decim  (decim),
      .o_tick_c (w_tick),
      .o_s_c    (w_s)
   );

   // Arm/trigger decisions use the arm flag as it stood before this tick.
   always_comb begin
      w_arm  = trig_slope ? (w_s > arm_above(trig_level))
                          : (w_s < arm_below(trig_level));
      w_trig = r_armed && (trig_slope ? (w_s <= trig_level) : (w_s >= trig_level));
      w_auto = auto_mode && (r_timeout == TMO_W'(AUTO_TIMEOUT));
   end

   // Capture FSM: wait for trigger, write one frame, then hold off.
   always_ff @(posedge clk_sample) begin
      if (!rst_n) begin
         r_state      <= WAIT_TRIG;
         r_armed      <= 1'b0;
         r_timeout    <= '0;
         r_hold       <= '0;
         r_addr       <= '0;
         r_wave       <= '0;
         r_wr_addr    <= '0;
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         r_wr_en      <= 1'b0;
         r_frame_done <= 1'b0;
         if (w_tick) begin
            case (r_state)
               WAIT_TRIG: begin
                  if (w_trig || w_auto) begin
                     r_state   <= CAPTURE;
                     r_armed   <= 1'b0;
                     r_timeout <= '0;
                     r_wr_en   <= 1'b1;
                     r_wave    <= w_s;
                     r_wr_addr <= '0;
                     r_addr    <= ADDR_W'(1);
                  end else begin
                     r_timeout <= r_timeout + TMO_W'(1);
                     if (w_arm) begin
                        r_armed <= 1'b1;
                     end
                  end
               end
               CAPTURE: begin
                  r_wr_en   <= 1'b1;
                  r_wave    <= w_s;
                  r_wr_addr <= r_addr;
                  if (r_addr == ADDR_W'(NUM_POINTS - 1)) begin
                     r_frame_done <= 1'b1;
                     r_state      <= HOLDOFF;
                     r_addr       <= '0;
                     r_hold       <= '0;
                  end else begin
                     r_addr <= r_addr + ADDR_W'(1);
                  end
               end
               HOLDOFF: begin
                  // The counter saturates so a long freeze releases on the next tick.
                  if (r_hold >= HOLD_W'(HOLDOFF_TICKS - 1)) begin
                     if (!freeze) begin
                        r_state   <= WAIT_TRIG;
                        r_armed   <= 1'b0;
                        r_timeout <= '0;
                        r_hold    <= '0;
                     end else begin
                        r_hold <= HOLD_W'(HOLDOFF_TICKS);
                     end
                  end else begin
                     r_hold <= r_hold + HOLD_W'(1);
                  end
               end
               default: begin
                  r_state   <= WAIT_TRIG;
                  r_armed   <= 1'b0;
                  r_timeout <= '0;
                  r_hold    <= '0;
                  r_addr    <= '0;
               end
            endcase
         end
      end
   end

   assign wave_sample = r_wave;
   assign wr_addr     = r_wr_addr;
   assign wr_en       = r_wr_en;
   assign frame_done  = r_frame_done;
   assign trig_state  = r_state;

endmodule

// File: tb/tb_wave_trigger_capture.sv
// Directed bench for wave_trigger_capture with a per-cycle behavioural reference.
module tb_wave_trigger_capture;

   logic        clk_sample;
   logic        rst_n;
   logic [11:0] mic_in;
   logic        mic_valid;
   logic [3:0]  decim;
   logic [9:0]  trig_level;
   logic        trig_slope;
   logic        auto_mode;
   logic        freeze;
   logic [9:0]  wave_sample;
   logic [10:0] wr_addr;
   logic        wr_en;
   logic        frame_done;
   logic [1:0]  trig_state;

   int n_checks = 0;
   int n_errors = 0;
   int n_wr     = 0;
   int n_done   = 0;
   bit chk_on   = 1'b0;

   // Reference state: mode 0 waiting, 1 capturing, 2 holding off.
   int md_mode, md_since, md_wait, md_pts, md_hold;
   bit md_armed;
   int m_en, m_done, m_wave, m_addr;
   int e_en, e_done, e_wave, e_addr, e_state;

   wave_trigger_capture dut (
      .clk_sample  (clk_sample),
      .rst_n       (rst_n),
      .mic_in      (mic_in),
      .mic_valid   (mic_valid),
      .decim       (decim),
      .trig_level  (trig_level),
      .trig_slope  (trig_slope),
      .auto_mode   (auto_mode),
      .freeze      (freeze),
      .wave_sample (wave_sample),
      .wr_addr     (wr_addr),
      .wr_en       (wr_en),
      .frame_done  (frame_done),
      .trig_state  (trig_state)
   );

   initial clk_sample = 1'b0;
   always #5 clk_sample = ~clk_sample;

   function automatic void chk(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endfunction

   // Expected outputs after the coming clock edge, from the current inputs.
   task automatic model_step();
      int  s, lo, hi;
      bit  tick, hit;
      if (!rst_n) begin
         md_mode = 0; md_armed = 1'b0; md_since = 0; md_wait = 0; md_pts = 0; md_hold = 0;
         m_en = 0; m_done = 0; m_wave = 0; m_addr = 0;
         return;
      end
      m_en   = 0;
      m_done = 0;
      if (!mic_valid) return;
      s    = int'(mic_in) / 4;
      tick = (md_since >= int'(decim));
      md_since = tick ? 0 : md_since + 1;
      if (!tick) return;
      case (md_mode)
         0: begin
            lo = int'(trig_level) - 8;
            if (lo < 0) lo = 0;
            hi = int'(trig_level) + 8;
            if (hi > 1023) hi = 1023;
            hit = md_armed && (trig_slope ? (s <= int'(trig_level)) : (s >= int'(trig_level)));
            if (hit || (auto_mode && md_wait == 4095)) begin
               md_mode = 1; md_armed = 1'b0; md_wait = 0;
               m_en = 1; m_wave = s; m_addr = 0; md_pts = 1;
            end else begin
               if (trig_slope ? (s > hi) : (s < lo)) md_armed = 1'b1;
               md_wait = (md_wait + 1) % 4096;
            end
         end
         1: begin
            m_en = 1; m_wave = s; m_addr = md_pts;
            md_pts++;
            if (md_pts == 1280) begin
               m_done = 1; md_mode = 2; md_hold = 0; md_pts = 0;
            end
         end
         default: begin
            md_hold++;
            if (md_hold >= 64 && !freeze) begin
               md_mode = 0; md_armed = 1'b0; md_wait = 0;
            end
         end
      endcase
   endtask

   task automatic step(input bit v, input int s);
      mic_valid = v;
      mic_in    = 12'(s * 4 + int'($urandom_range(3, 0)));
      model_step();
      @(posedge clk_sample);
      #1;
      e_en = m_en; e_done = m_done; e_wave = m_wave; e_addr = m_addr; e_state = md_mode;
      chk_on = 1'b1;
   endtask

   // Per-cycle comparison against the reference.
   always @(negedge clk_sample) begin
      if (chk_on) begin
         chk("wr_en", int'(wr_en), e_en);
         chk("frame_done", int'(frame_done), e_done);
         chk("trig_state", int'(trig_state), e_state);
         chk("wr_addr", int'(wr_addr), e_addr);
         chk("wave_sample", int'(wave_sample), e_wave);
         if (wr_en === 1'b1) n_wr++;
         if (frame_done === 1'b1) n_done++;
      end
   end

   initial begin
      int nv;
      rst_n = 1'b0; mic_valid = 1'b0; mic_in = '0; decim = 4'd0;
      trig_level = 10'd512; trig_slope = 1'b0; auto_mode = 1'b0; freeze = 1'b0;

      // Reset while streaming, then a quiet signal that never arms.
      for (int i = 0; i < 5; i++) step(1'b1, int'($urandom_range(1023, 0)));
      chk("t1_rst_wr_en", int'(wr_en), 0);
      chk("t1_rst_state", int'(trig_state), 0);
      chk("t1_rst_done", int'(frame_done), 0);
      chk("t1_rst_addr", int'(wr_addr), 0);
      rst_n = 1'b1;
      for (int i = 0; i < 10000; i++) step(1'b1, 600);
      chk("t1_no_writes", n_wr, 0);

      // Rising ramp through 512, full frame, then holdoff.
      for (int k = 0; k <= 1455; k++) begin
         step(1'b1, 400 + k % 201);
         if (k == 111) chk("t2_pre_wr_en", int'(wr_en), 0);
         if (k == 112) begin
            chk("t2_trig_wr_en", int'(wr_en), 1);
            chk("t2_trig_wave", int'(wave_sample), 512);
            chk("t2_trig_addr", int'(wr_addr), 0);
            chk("t2_trig_state", int'(trig_state), 1);
         end
         if (k == 1391) begin
            chk("t2_last_done", int'(frame_done), 1);
            chk("t2_last_addr", int'(wr_addr), 1279);
            chk("t2_last_wave", int'(wave_sample), 585);
         end
         if (k == 1454) chk("t2_hold_state", int'(trig_state), 2);
         if (k == 1455) chk("t2_exit_state", int'(trig_state), 0);
      end

      // Falling slope: noise inside the hysteresis band never arms.
      trig_slope = 1'b1;
      trig_level = 10'd300;
      for (int i = 0; i < 200; i++) step((i % 7) != 3, 295 + int'($urandom_range(10, 0)));
      chk("t3_noise_state", int'(trig_state), 0);
      step(1'b1, 320);
      chk("t3_arm_wr_en", int'(wr_en), 0);
      step(1'b1, 300);
      chk("t3_trig_wr_en", int'(wr_en), 1);
      chk("t3_trig_wave", int'(wave_sample), 300);
      chk("t3_trig_addr", int'(wr_addr), 0);
      for (int i = 0; i < 1343; i++) step(1'b1, 300);
      chk("t3_exit_state", int'(trig_state), 0);

      // Auto-trigger on a flat signal with 4:1 decimation and gaps in mic_valid.
      auto_mode = 1'b1;
      decim     = 4'd3;
      nv        = 0;
      while (nv < 21756) begin
         nv++;
         step(1'b1, 100);
         if (nv == 16383) chk("t4_pre_state", int'(trig_state), 0);
         if (nv == 16384) begin
            chk("t4_auto_wr_en", int'(wr_en), 1);
            chk("t4_auto_addr", int'(wr_addr), 0);
            chk("t4_auto_wave", int'(wave_sample), 100);
            chk("t4_auto_state", int'(trig_state), 1);
         end
         if (nv == 16388) chk("t4_second_addr", int'(wr_addr), 1);
         if (nv == 21500) begin
            chk("t4_last_done", int'(frame_done), 1);
            chk("t4_last_addr", int'(wr_addr), 1279);
         end
         if (nv == 21755) chk("t4_hold_state", int'(trig_state), 2);
         if (nv == 21756) chk("t4_exit_state", int'(trig_state), 0);
         if (nv % 5 == 0) step(1'b0, 100);
      end
      auto_mode = 1'b0;

      // Freeze mid-capture: frame completes, holdoff held until release.
      decim      = 4'd0;
      trig_slope = 1'b0;
      trig_level = 10'd512;
      for (int k = 0; k <= 1592; k++) begin
         if (k == 712) freeze = 1'b1;
         if (k == 1592) freeze = 1'b0;
         step(1'b1, 400 + k % 201);
         if (k == 712) chk("t5_freeze_addr", int'(wr_addr), 600);
         if (k == 1391) begin
            chk("t5_last_done", int'(frame_done), 1);
            chk("t5_last_addr", int'(wr_addr), 1279);
         end
         if (k == 1591) chk("t5_frozen_state", int'(trig_state), 2);
         if (k == 1592) chk("t5_release_state", int'(trig_state), 0);
      end

      // Reset mid-frame aborts; next trigger restarts at 0; decim shrink mid-count.
      for (int k = 0; k <= 919; k++) begin
         rst_n = (k == 813) ? 1'b0 : 1'b1;
         if (k == 917) decim = 4'd3;
         if (k == 919) decim = 4'd1;
         step(1'b1, 400 + k % 201);
         if (k == 812) begin
            chk("t6_pre_addr", int'(wr_addr), 700);
            chk("t6_pre_wave", int'(wave_sample), 408);
         end
         if (k == 813) begin
            chk("t6_rst_wr_en", int'(wr_en), 0);
            chk("t6_rst_addr", int'(wr_addr), 0);
            chk("t6_rst_state", int'(trig_state), 0);
            chk("t6_rst_done", int'(frame_done), 0);
         end
         if (k == 916) begin
            chk("t6_retrig_wr_en", int'(wr_en), 1);
            chk("t6_retrig_addr", int'(wr_addr), 0);
            chk("t6_retrig_wave", int'(wave_sample), 512);
         end
         if (k == 917 || k == 918) chk("t6_decim_gap", int'(wr_en), 0);
         if (k == 919) begin
            chk("t6_shrink_wr_en", int'(wr_en), 1);
            chk("t6_shrink_addr", int'(wr_addr), 1);
            chk("t6_shrink_wave", int'(wave_sample), 515);
         end
      end
      for (int i = 0; i < 10; i++) step(1'b1, 420);
      chk("t6_frame_count", n_done, 4);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
